// File: rtl/div_issue_unit.sv
// Issue/return wrapper around a fixed-latency external divider: tracks in-flight
// operations, captures results into an in-order FIFO and gates requests with credits.
module div_issue_unit #(
  parameter int LATENCY    = 12,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [32:0]      div_numer,
  output logic [32:0]      div_denom,
  input  logic [32:0]      div_quotient,
  input  logic [32:0]      div_remain,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TRK_W   = TAG_W + 2;
  localparam int ENTRY_W = 32 + TAG_W;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Tracker entry layout: {valid, sel_rem, tag}; stage 0 is the oldest.
  logic [TRK_W-1:0]   trk_reg  [LATENCY];
  logic [TRK_W-1:0]   trk_next [LATENCY];

  logic               fire;
  logic               push;
  logic               pop;
  logic               req_ready_reg;
  logic               req_ready_next;
  logic [CNT_W-1:0]   credits_used_reg;
  logic [CNT_W-1:0]   credits_used_next;
  logic [CNT_W-1:0]   fifo_count_reg;
  logic [CNT_W-1:0]   fifo_count_next;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [31:0]        result_sel;
  logic               unused_msb;

  // Signed ops sign-extend so the 33-bit divider also covers the unsigned range.
  assign div_numer = req_op[0] ? {1'b0, req_a} : {req_a[31], req_a};
  assign div_denom = req_op[0] ? {1'b0, req_b} : {req_b[31], req_b};

  assign fire      = req_valid & req_ready_reg;
  assign req_ready = req_ready_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_trk
      if (gi == LATENCY - 1) begin : g_entry
        assign trk_next[gi] = {fire, req_op[1], req_tag};
      end else begin : g_shift
        assign trk_next[gi] = trk_reg[gi + 1];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        trk_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        trk_reg[i] <= trk_next[i];
      end
    end
  end

  // Divider results are consumed as-is, including divide-by-zero and overflow cases.
  assign push       = trk_reg[0][TRK_W-1];
  assign result_sel = trk_reg[0][TAG_W] ? div_remain[31:0] : div_quotient[31:0];
  assign push_entry = {result_sel, trk_reg[0][TAG_W-1:0]};
  assign unused_msb = div_quotient[32] ^ div_remain[32];

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  assign head_entry = fifo_mem[rd_ptr_reg];
  assign resp_valid = (fifo_count_reg != '0);
  assign resp_data  = head_entry[ENTRY_W-1:TAG_W];
  assign resp_tag   = head_entry[TAG_W-1:0];
  assign pop        = resp_valid & resp_ready;

  // Credits cover both in-flight tracker entries and buffered results, so the FIFO cannot overflow.
  always_comb begin
    credits_used_next = credits_used_reg;
    if (fire && !pop) begin
      credits_used_next = credits_used_reg + CNT_ONE;
    end else if (pop && !fire) begin
      credits_used_next = credits_used_reg - CNT_ONE;
    end

    fifo_count_next = fifo_count_reg;
    if (push && !pop) begin
      fifo_count_next = fifo_count_reg + CNT_ONE;
    end else if (pop && !push) begin
      fifo_count_next = fifo_count_reg - CNT_ONE;
    end

    req_ready_next = (credits_used_next < CNT_FULL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      credits_used_reg <= '0;
      fifo_count_reg   <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      req_ready_reg    <= 1'b0;
    end else begin
      credits_used_reg <= credits_used_next;
      fifo_count_reg   <= fifo_count_next;
      req_ready_reg    <= req_ready_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit with a behavioural fixed-latency divider model.
module tb_div_issue_unit;

  localparam int LATENCY    = 12;
  localparam int TAG_W      = 5;
  localparam int FIFO_DEPTH = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic [32:0]      div_numer;
  logic [32:0]      div_denom;
  logic [32:0]      div_quotient;
  logic [32:0]      div_remain;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fire_cyc = 0;

  logic [32:0] pipe_q [LATENCY];
  logic [32:0] pipe_r [LATENCY];

  div_issue_unit #(
    .LATENCY   (LATENCY),
    .TAG_W     (TAG_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .div_numer   (div_numer),
    .div_denom   (div_denom),
    .div_quotient(div_quotient),
    .div_remain  (div_remain),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_tag    (resp_tag)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // External divider: samples every edge, result visible LATENCY-1 edges later.
  function automatic logic [32:0] model_q(input logic [32:0] n, input logic [32:0] d);
    if (d == 33'd0) return '1;
    return $signed(n) / $signed(d);
  endfunction

  function automatic logic [32:0] model_r(input logic [32:0] n, input logic [32:0] d);
    if (d == 33'd0) return n;
    return $signed(n) % $signed(d);
  endfunction

  always @(posedge clock) begin
    pipe_q[0] <= model_q(div_numer, div_denom);
    pipe_r[0] <= model_r(div_numer, div_denom);
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
      pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign div_quotient = pipe_q[LATENCY-1];
  assign div_remain   = pipe_r[LATENCY-1];

  task automatic present(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    @(negedge clock);
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    #1;
  endtask

  task automatic fire_now();
    @(posedge clock);
    #1;
    fire_cyc  = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] data, output logic [TAG_W-1:0] tag);
    lat = -1; data = '0; tag = '0;
    for (int k = 0; k < 4*LATENCY; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = cyc - fire_cyc; data = resp_data; tag = resp_tag;
        break;
      end
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b0; resp_ready = 1'b1; req_op = 2'b00;
    req_a = '0; req_b = 32'd1; req_tag = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready: got %b expected 1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_resp_valid: got %b expected 0", resp_valid); end
    $display("reset: req_ready=%b resp_valid=%b", req_ready, resp_valid);
  endtask

  task automatic test_signed();
    int lat; logic [31:0] d; logic [TAG_W-1:0] t;
    present(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
    n_checks++;
    if (div_numer !== 33'h1_FFFF_FFF9) begin n_fail++; $display("FAIL div_signed_numer: got %h expected 1fffffff9", div_numer); end
    n_checks++;
    if (div_denom !== 33'h0_0000_0002) begin n_fail++; $display("FAIL div_signed_denom: got %h expected 000000002", div_denom); end
    fire_now();
    wait_resp(lat, d, t);
    $display("DIV -7/2: lat=%0d data=%h tag=%0d", lat, d, t);
    n_checks++;
    if (lat !== LATENCY) begin n_fail++; $display("FAIL div_signed_latency: got %0d expected %0d", lat, LATENCY); end
    n_checks++;
    if (d !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_signed_data: got %h expected fffffffd", d); end
    n_checks++;
    if (t !== 5'd3) begin n_fail++; $display("FAIL div_signed_tag: got %0d expected 3", t); end

    present(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);
    fire_now();
    wait_resp(lat, d, t);
    $display("REM -7/2: lat=%0d data=%h tag=%0d", lat, d, t);
    n_checks++;
    if (lat !== LATENCY) begin n_fail++; $display("FAIL rem_signed_latency: got %0d expected %0d", lat, LATENCY); end
    n_checks++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_signed_data: got %h expected ffffffff", d); end
    n_checks++;
    if (t !== 5'd3) begin n_fail++; $display("FAIL rem_signed_tag: got %0d expected 3", t); end
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] d; logic [TAG_W-1:0] t;
    present(2'b01, 32'hFFFF_FFFF, 32'd2, 5'd7);
    n_checks++;
    if (div_numer !== 33'h0_FFFF_FFFF) begin n_fail++; $display("FAIL divu_numer: got %h expected 0ffffffff", div_numer); end
    fire_now();
    wait_resp(lat, d, t);
    $display("DIVU ffffffff/2: lat=%0d data=%h tag=%0d", lat, d, t);
    n_checks++;
    if (d !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL divu_data: got %h expected 7fffffff", d); end
    n_checks++;
    if (t !== 5'd7) begin n_fail++; $display("FAIL divu_tag: got %0d expected 7", t); end

    present(2'b11, 32'hFFFF_FFFF, 32'd2, 5'd8);
    fire_now();
    wait_resp(lat, d, t);
    $display("REMU ffffffff/2: lat=%0d data=%h tag=%0d", lat, d, t);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL remu_data: got %h expected 00000001", d); end
    n_checks++;
    if (t !== 5'd8) begin n_fail++; $display("FAIL remu_tag: got %0d expected 8", t); end
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] d; logic [TAG_W-1:0] t;
    logic [1:0]  ops [4];
    logic [31:0] va  [4];
    logic [31:0] vb  [4];
    logic [31:0] exp [4];
    ops = '{2'b00, 2'b11, 2'b00, 2'b10};
    va  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    vb  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 4; i++) begin
      present(ops[i], va[i], vb[i], 5'(10 + i));
      fire_now();
      wait_resp(lat, d, t);
      $display("special[%0d] op=%b a=%h b=%h: lat=%0d data=%h tag=%0d", i, ops[i], va[i], vb[i], lat, d, t);
      n_checks++;
      if (d !== exp[i]) begin n_fail++; $display("FAIL special_data[%0d]: got %h expected %h", i, d, exp[i]); end
      n_checks++;
      if (t !== 5'(10 + i)) begin n_fail++; $display("FAIL special_tag[%0d]: got %0d expected %0d", i, t, 10 + i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [3];
    logic [31:0] va  [3];
    logic [31:0] vb  [3];
    logic [31:0] exp [3];
    int first_fire = 0;
    int got = 0;
    ops = '{2'b01, 2'b11, 2'b00};
    va  = '{32'd100, 32'd100, 32'hFFFF_FF9C};
    vb  = '{32'd10, 32'd7, 32'd7};
    exp = '{32'd10, 32'd2, 32'hFFFF_FFF2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_op = ops[i]; req_a = va[i]; req_b = vb[i]; req_tag = 5'(i + 1); req_valid = 1'b1;
      if (i == 1) first_fire = cyc;
    end
    @(negedge clock);
    req_valid = 1'b0;
    for (int k = 0; k < 4*LATENCY && got < 3; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        $display("b2b[%0d]: cyc=%0d data=%h tag=%0d", got, cyc - first_fire, resp_data, resp_tag);
        n_checks++;
        if (resp_data !== exp[got]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", got, resp_data, exp[got]); end
        n_checks++;
        if (resp_tag !== 5'(got + 1)) begin n_fail++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", got, resp_tag, got + 1); end
        n_checks++;
        if (cyc !== first_fire + LATENCY + got) begin
          n_fail++; $display("FAIL b2b_timing[%0d]: got %0d expected %0d", got, cyc - first_fire, LATENCY + got);
        end
        got++;
      end
    end
    n_checks++;
    if (got !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", got); end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    int got = 0;
    @(negedge clock);
    resp_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clock);
      req_op = 2'b01; req_a = 32'(1000 + 3*accepted); req_b = 32'd3;
      req_tag = 5'(accepted); req_valid = 1'b1;
      if (k >= 30) begin
        n_checks++;
        if (resp_valid !== 1'b1 || resp_tag !== 5'd0 || resp_data !== 32'd333) begin
          n_fail++; $display("FAIL bp_head_stable: got valid=%b tag=%0d data=%0d expected 1/0/333", resp_valid, resp_tag, resp_data);
        end
      end
      if (req_ready) accepted++;
    end
    $display("backpressure: accepted=%0d req_ready=%b", accepted, req_ready);
    n_checks++;
    if (accepted !== FIFO_DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, FIFO_DEPTH); end
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", req_ready); end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_pop: got %b expected 0", req_ready); end
    for (int k = 0; k < 40 && got < FIFO_DEPTH; k++) begin
      if (k > 0) @(negedge clock);
      if (k == 1) begin
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
      end
      if (resp_valid) begin
        $display("drain[%0d]: data=%0d tag=%0d", got, resp_data, resp_tag);
        n_checks++;
        if (resp_tag !== 5'(got)) begin n_fail++; $display("FAIL bp_tag[%0d]: got %0d expected %0d", got, resp_tag, got); end
        n_checks++;
        if (resp_data !== 32'(333 + got)) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected %0d", got, resp_data, 333 + got); end
        got++;
      end
    end
    n_checks++;
    if (got !== FIFO_DEPTH) begin n_fail++; $display("FAIL bp_drain_count: got %0d expected %0d", got, FIFO_DEPTH); end
  endtask

  task automatic test_reset_midflight();
    int lat; logic [31:0] d; logic [TAG_W-1:0] t;
    int seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      req_op = 2'b01; req_a = 32'd50; req_b = 32'd5; req_tag = 5'(20 + i); req_valid = 1'b1;
    end
    @(negedge clock);
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midflight_in_reset: got ready=%b valid=%b expected 0/0", req_ready, resp_valid);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 2*LATENCY; k++) begin
      @(negedge clock);
      if (k == 0) begin
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midflight_ready: got %b expected 1", req_ready); end
      end
      if (resp_valid) seen++;
    end
    $display("midflight: stale responses seen=%0d", seen);
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midflight_discard: got %0d responses expected 0", seen); end
    present(2'b00, 32'd100, 32'd7, 5'd9);
    fire_now();
    wait_resp(lat, d, t);
    $display("after reset DIV 100/7: lat=%0d data=%0d tag=%0d", lat, d, t);
    n_checks++;
    if (lat !== LATENCY) begin n_fail++; $display("FAIL midflight_new_latency: got %0d expected %0d", lat, LATENCY); end
    n_checks++;
    if (d !== 32'd14 || t !== 5'd9) begin n_fail++; $display("FAIL midflight_new_result: got %0d/%0d expected 14/9", d, t); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
